// File: rtl/axi_slave_mem_if.sv
// AXI-style bus bundle between a burst master and the axi_slave_mem responder.
//
// Handshake rule for every channel: a transfer happens at the rising edge of
// aclk at which both valid and ready are high. The source keeps valid and its
// payload stable until that edge. The slave's outputs are registered and do
// not change while its valid is high and ready is low.
interface axi_slave_mem_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADD_WIDTH  = 8,
  parameter int ID_WIDTH   = 8
) ();
  localparam int NB = DATA_WIDTH / 8;

  // write address channel
  logic                  awvalid;
  logic                  awready;
  logic [ADD_WIDTH-1:0]  awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [ID_WIDTH-1:0]   awid;
  // write data channel
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [NB-1:0]         wstrb;
  logic                  wlast;
  logic [ID_WIDTH-1:0]   wid;
  // write response channel
  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  // read address channel
  logic                  arvalid;
  logic                  arready;
  logic [ADD_WIDTH-1:0]  araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [ID_WIDTH-1:0]   arid;
  // read data channel
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ID_WIDTH-1:0]   rid;
  logic                  rlast;
  logic [1:0]            rresp;

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awid,
    output awready,
    input  wvalid, wdata, wstrb, wlast, wid,
    output wready,
    output bvalid, bid, bresp,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arid,
    output arready,
    output rvalid, rdata, rid, rlast, rresp,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awlen, awsize, awid,
    input  awready,
    output wvalid, wdata, wstrb, wlast, wid,
    input  wready,
    input  bvalid, bid, bresp,
    output bready,
    output arvalid, araddr, arlen, arsize, arid,
    input  arready,
    input  rvalid, rdata, rid, rlast, rresp,
    output rready
  );
endinterface

// File: rtl/axi_slave_mem.sv
// Byte-addressed burst memory target. One write burst and one read burst may
// be in flight at a time; the two directions run independently. Every bus
// output comes straight from a flop, so no input reaches an output in the
// same cycle.
module axi_slave_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADD_WIDTH  = 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic            aclk,
  input  logic            areset,
  axi_slave_mem_if.slave  bus,
  output logic [1:0]      dbg_w_state,
  output logic [1:0]      dbg_r_state
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADD_WIDTH;
  // beat sizes wider than the bus are flagged and then moved as full-bus beats
  localparam logic [2:0] MAX_SIZE = 3'($clog2(NB));
  localparam logic [ADD_WIDTH-1:0] ALIGN_MASK = ~(ADD_WIDTH'(NB - 1));

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_DATA = 2'd1} r_state_t;

  logic [7:0] mem [DEPTH];

  // ---------------- write side ----------------
  w_state_t              w_state_q, w_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [ADD_WIDTH-1:0]  w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  w_err_q, w_err_d;
  logic                  w_fire;
  logic                  w_beat_err;
  logic [ADD_WIDTH-1:0]  w_incr;
  logic [ADD_WIDTH-1:0]  w_lane_addr [NB];

  // write FSM: next state, burst bookkeeping and registered handshake outputs
  always_comb begin
    w_state_d  = w_state_q;
    w_id_d     = w_id_q;
    w_addr_d   = w_addr_q;
    w_len_d    = w_len_q;
    w_size_d   = w_size_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    bresp_d    = bresp_q;
    w_fire     = bus.wvalid && wready_q;
    w_incr     = ADD_WIDTH'(1) << w_size_q;
    w_beat_err = (bus.wlast != (w_cnt_q == w_len_q)) || (bus.wid != w_id_q);
    case (w_state_q)
      W_IDLE: begin
        if (bus.awvalid && awready_q) begin
          w_id_d    = bus.awid;
          w_addr_d  = bus.awaddr;
          w_len_d   = bus.awlen;
          w_size_d  = (bus.awsize > MAX_SIZE) ? MAX_SIZE : bus.awsize;
          w_cnt_d   = 8'd0;
          w_err_d   = (bus.awsize > MAX_SIZE);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          w_err_d  = w_err_q | w_beat_err;
          w_addr_d = w_addr_q + w_incr;
          w_cnt_d  = w_cnt_q + 8'd1;
          if (w_cnt_q == w_len_q) begin
            bresp_d   = (w_err_q | w_beat_err) ? 2'b10 : 2'b00;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && bus.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // write state and output registers; reset drops any burst without a response
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
    end
  end

  // byte address of each lane for the current write beat (wraps at the top)
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      w_lane_addr[i] = (w_addr_q & ALIGN_MASK) + ADD_WIDTH'(i);
    end
  end

  // RAM write: strobed lanes are stored at the W handshake edge
  always_ff @(posedge aclk) begin
    if (w_fire) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wstrb[i]) mem[w_lane_addr[i]] <= bus.wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read side ----------------
  r_state_t              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADD_WIDTH-1:0]  r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  r_load;
  logic [ADD_WIDTH-1:0]  r_load_addr;
  logic [ADD_WIDTH-1:0]  r_incr;

  // read FSM: next state, beat advance, and the data word for the next beat.
  // rdata is loaded only when a new beat starts, so it cannot change while
  // the master stalls; a write landing at that same edge is seen one beat later.
  always_comb begin
    r_state_d   = r_state_q;
    rid_d       = rid_q;
    rresp_d     = rresp_q;
    r_addr_d    = r_addr_q;
    r_len_d     = r_len_q;
    r_size_d    = r_size_q;
    r_cnt_d     = r_cnt_q;
    rdata_d     = rdata_q;
    r_load      = 1'b0;
    r_load_addr = r_addr_q;
    r_incr      = ADD_WIDTH'(1) << r_size_q;
    case (r_state_q)
      R_IDLE: begin
        if (bus.arvalid && arready_q) begin
          rid_d       = bus.arid;
          rresp_d     = (bus.arsize > MAX_SIZE) ? 2'b10 : 2'b00;
          r_addr_d    = bus.araddr;
          r_len_d     = bus.arlen;
          r_size_d    = (bus.arsize > MAX_SIZE) ? MAX_SIZE : bus.arsize;
          r_cnt_d     = 8'd0;
          r_load      = 1'b1;
          r_load_addr = bus.araddr;
          r_state_d   = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && bus.rready) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d     = r_cnt_q + 8'd1;
            r_addr_d    = r_addr_q + r_incr;
            r_load      = 1'b1;
            r_load_addr = r_addr_q + r_incr;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rlast_d   = rvalid_d && (r_cnt_d == r_len_d);
    if (r_load) begin
      for (int i = 0; i < NB; i++) begin
        rdata_d[8*i +: 8] = mem[(r_load_addr & ALIGN_MASK) + ADD_WIDTH'(i)];
      end
    end else if (!rvalid_d) begin
      rdata_d = '0;
    end
  end

  // read state and output registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rid_q     <= '0;
      rdata_q   <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_cnt_q   <= r_cnt_d;
    end
  end

  assign bus.awready  = awready_q;
  assign bus.wready   = wready_q;
  assign bus.bvalid   = bvalid_q;
  assign bus.bid      = w_id_q;
  assign bus.bresp    = bresp_q;
  assign bus.arready  = arready_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.rid      = rid_q;
  assign bus.rlast    = rlast_q;
  assign bus.rresp    = rresp_q;
  assign dbg_w_state  = w_state_q;
  assign dbg_r_state  = r_state_q;
endmodule
